// File: rtl/clock_div_cfg_pkg.sv
// Shared constants and FSM encoding for the serial config loader of the
// 4-channel clock divider/selector.
package clock_div_cfg_pkg;

    // Config word width; a frame is CFG_W data bits followed by one parity bit.
    localparam int CFG_W = 26;

    // Field layout of the config word driven into the divider.
    localparam int SEL_LSB  = 0;
    localparam int SEL_W    = 2;
    localparam int DIVA_LSB = 2;
    localparam int DIVB_LSB = 8;
    localparam int DIVC_LSB = 14;
    localparam int DIVD_LSB = 20;
    localparam int DIV_W    = 6;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/clock_div_cfg_loader_if.sv
// 3-wire serial configuration link (frame enable, serial clock, serial data).
interface clock_div_cfg_loader_if;

    logic cs_n;
    logic sck;
    logic sdi;

    // The host drives the link.
    modport master (output cs_n, output sck, output sdi);

    // The loader only observes the link.
    modport slave (input cs_n, input sck, input sdi);

endinterface

// File: rtl/cfg_sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit.
module cfg_sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw input through the flop chain; the reset value is the
    // pin's idle level so no false edge is seen when reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/clock_div_cfg_loader.sv
// Serial configuration loader: captures a CFG_W+1 bit frame (data MSB first,
// then an even-parity bit) and commits the data word to cfg only when the
// frame has the exact length and correct parity.
module clock_div_cfg_loader #(
    parameter int               CFG_W       = clock_div_cfg_pkg::CFG_W,
    parameter int               SYNC_STAGES = 2,
    parameter logic [CFG_W-1:0] RESET_CFG   = {CFG_W{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    clock_div_cfg_loader_if.slave  link,
    output logic [CFG_W-1:0]       cfg,
    output logic                   cfg_valid,
    output logic                   frame_err,
    output logic                   busy
);

    import clock_div_cfg_pkg::*;

    // Counter saturates at CFG_W+2 so any over-long frame stays distinguishable.
    localparam int              CNT_W     = $clog2(CFG_W + 3);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CFG_W + 2);

    logic              cs_n_s;
    logic              sck_s;
    logic              sdi_s;
    logic              cs_n_prev_r;
    logic              sck_prev_r;
    logic              sck_rise_s;
    logic              cs_rise_s;
    logic              frame_ok_s;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CFG_W:0]    shadow_r;
    logic [CFG_W:0]    shadow_nxt_s;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  bit_cnt_nxt_s;
    logic [CFG_W-1:0]  cfg_r;
    logic [CFG_W-1:0]  cfg_nxt_s;
    logic              cfg_valid_r;
    logic              cfg_valid_nxt_s;
    logic              frame_err_r;
    logic              frame_err_nxt_s;
    logic              busy_r;

    // Even parity over data plus parity bit: the XOR of all bits must be zero.
    function automatic logic parity_ok(input logic [CFG_W:0] frame);
        return ~(^frame);
    endfunction

    cfg_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .rst_n(rst_n), .d(link.cs_n), .q(cs_n_s)
    );
    cfg_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d(link.sck), .q(sck_s)
    );
    cfg_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .d(link.sdi), .q(sdi_s)
    );

    // Keep the previous synced level of cs_n and sck for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_n_prev_r <= 1'b1;
            sck_prev_r  <= 1'b0;
        end else begin
            cs_n_prev_r <= cs_n_s;
            sck_prev_r  <= sck_s;
        end
    end

    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign cs_rise_s  = cs_n_s & ~cs_n_prev_r;
    assign frame_ok_s = (bit_cnt_r == CNT_FRAME) && parity_ok(shadow_r);

    // Next-state, shift/count and commit decisions for the loader FSM.
    always_comb begin
        state_nxt_s     = state_r;
        shadow_nxt_s    = shadow_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        cfg_nxt_s       = cfg_r;
        cfg_valid_nxt_s = 1'b0;
        frame_err_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!cs_n_s) begin
                    state_nxt_s   = SHIFT;
                    shadow_nxt_s  = {(CFG_W + 1){1'b0}};
                    bit_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                // End of frame wins over a coincident sck edge.
                if (cs_rise_s) begin
                    state_nxt_s = CHECK;
                end else if (sck_rise_s && !cs_n_s) begin
                    shadow_nxt_s = {shadow_r[CFG_W-1:0], sdi_s};
                    if (bit_cnt_r != CNT_SAT) begin
                        bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            CHECK: begin
                state_nxt_s = IDLE;
                if (frame_ok_s) begin
                    cfg_nxt_s       = shadow_r[CFG_W:1];
                    cfg_valid_nxt_s = 1'b1;
                end else begin
                    frame_err_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Register FSM state, shadow frame, counter and all outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            shadow_r    <= {(CFG_W + 1){1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
            cfg_r       <= RESET_CFG;
            cfg_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            shadow_r    <= shadow_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            cfg_r       <= cfg_nxt_s;
            cfg_valid_r <= cfg_valid_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign cfg       = cfg_r;
    assign cfg_valid = cfg_valid_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_clock_div_cfg_loader.sv
// Self-checking bench for clock_div_cfg_loader: directed and random frames
// are scored against a frame-level model (length and parity rules).
module tb_clock_div_cfg_loader;

    import clock_div_cfg_pkg::*;

    typedef struct {
        bit          ok;
        logic [25:0] word;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [25:0] cfg;
    logic        cfg_valid;
    logic        frame_err;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          mon_en  = 1'b0;
    logic [25:0] model_cfg;
    logic [25:0] last_cfg;
    exp_t        exp_q[$];
    bit          tx_q[$];

    clock_div_cfg_loader_if link ();

    clock_div_cfg_loader #(
        .CFG_W(CFG_W), .SYNC_STAGES(2), .RESET_CFG(26'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .link(link),
        .cfg(cfg), .cfg_valid(cfg_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [25:0] d, input logic p);
        for (int i = 25; i >= 0; i--) tx_q.push_back(d[i]);
        tx_q.push_back(p);
    endtask

    task automatic send_bit(input bit b, input int half);
        link.sdi = b;
        link.sck = 1'b0;
        tick(half);
        link.sck = 1'b1;
        tick(half);
    endtask

    // Send tx_q as one frame and queue the outcome the frame rules predict.
    task automatic send_frame(input int half, input int gap);
        int          ones;
        logic [25:0] w;
        exp_t        e;
        ones = 0;
        w    = 26'd0;
        foreach (tx_q[i]) ones += int'(tx_q[i]);
        for (int i = 0; i < 26 && i < tx_q.size(); i++) w[25-i] = tx_q[i];
        e.ok   = (tx_q.size() == 27) && (ones % 2 == 0);
        e.word = w;
        link.cs_n = 1'b0;
        tick(4);
        foreach (tx_q[i]) send_bit(tx_q[i], half);
        link.sck = 1'b0;
        tick(half);
        check_eq("busy_in_frame", {31'd0, busy}, 32'd1);
        link.cs_n = 1'b1;
        e.cyc = cyc;
        exp_q.push_back(e);
        tx_q.delete();
        tick(gap);
    endtask

    task automatic drain(input string tag);
        tick(12);
        check_eq({tag, "_drained"}, exp_q.size(), 32'd0);
        check_eq({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard: every pulse must match the oldest expected frame outcome,
    // arrive exactly 4 cycles after the cs_n pin rose, and cfg may only move
    // together with cfg_valid.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            model_cfg = 26'd0;
        end else if (mon_en) begin
            if (cfg_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pulse", {30'd0, cfg_valid, frame_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("pulse_kind", {30'd0, cfg_valid, frame_err}, e.ok ? 32'd2 : 32'd1);
                    check_eq("pulse_latency", cyc - e.cyc, 32'd4);
                    if (e.ok) model_cfg = e.word;
                    check_eq("cfg_value", {6'd0, cfg}, {6'd0, model_cfg});
                end
            end
            if (cfg !== last_cfg) check_eq("cfg_change_needs_valid", {31'd0, cfg_valid}, 32'd1);
        end
        last_cfg = cfg;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [25:0] d;
        logic        p;
        int          len;
        int          pick;

        // 1. Reset with random pin activity.
        rst_n     = 1'b0;
        link.cs_n = 1'b1;
        link.sck  = 1'b0;
        link.sdi  = 1'b0;
        repeat (3) begin
            link.cs_n = 1'($urandom);
            link.sck  = 1'($urandom);
            link.sdi  = 1'($urandom);
            tick(1);
        end
        check_eq("reset_cfg", {6'd0, cfg}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_pulses", {30'd0, cfg_valid, frame_err}, 32'd0);
        link.cs_n = 1'b1;
        link.sck  = 1'b0;
        rst_n     = 1'b1;
        tick(6);
        check_eq("post_reset_cfg", {6'd0, cfg}, 32'd0);
        check_eq("post_reset_pulses", {30'd0, cfg_valid, frame_err}, 32'd0);
        mon_en = 1'b1;

        // 2. Good frame at sck = clk/8.
        push_word(26'h1234567, 1'b0);
        send_frame(4, 4);
        drain("good");
        check_eq("good_frame_cfg", {6'd0, cfg}, 32'h1234567);

        // 3. Bad parity: cfg must hold.
        push_word(26'h1234567, 1'b1);
        send_frame(4, 4);
        drain("bad_parity");
        check_eq("bad_parity_cfg", {6'd0, cfg}, 32'h1234567);

        // 4. Length errors: 26 bits, 28 bits, zero bits.
        push_word(26'h2AAAAAA, 1'b0);
        void'(tx_q.pop_back());
        send_frame(4, 4);
        push_word(26'h0F0F0F0, 1'b0);
        tx_q.push_back(1'b0);
        send_frame(4, 4);
        send_frame(4, 4);
        drain("length");
        check_eq("length_cfg", {6'd0, cfg}, 32'h1234567);

        // 5. Back-to-back frames with cs_n high for 2 clk between them.
        push_word(26'h0000001, 1'b1);
        send_frame(4, 2);
        push_word(26'h3FFFFFF, 1'b0);
        send_frame(4, 4);
        drain("b2b");
        check_eq("b2b_cfg", {6'd0, cfg}, 32'h3FFFFFF);

        // 6. Reset at bit 13, then a fresh good frame.
        push_word(26'h0ABCDEF, 1'b1);
        link.cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < 13; i++) send_bit(tx_q[i], 4);
        tx_q.delete();
        rst_n     = 1'b0;
        link.cs_n = 1'b1;
        link.sck  = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        check_eq("abort_reset_cfg", {6'd0, cfg}, 32'd0);
        push_word(26'h0ABCDEF, 1'b1);
        send_frame(4, 4);
        drain("abort");
        check_eq("abort_then_good_cfg", {6'd0, cfg}, 32'h0ABCDEF);

        // Random frames: random data, length, parity, sck rate and gap.
        for (int r = 0; r < 10; r++) begin
            d    = 26'($urandom);
            p    = ^d;
            if ($urandom_range(0, 2) == 0) p = ~p;
            pick = int'($urandom_range(0, 5));
            len  = (pick == 0) ? 25 : (pick == 1) ? 26 : (pick == 5) ? 28 : 27;
            push_word(d, p);
            while (tx_q.size() > len) void'(tx_q.pop_back());
            while (tx_q.size() < len) tx_q.push_back(1'($urandom));
            send_frame(int'($urandom_range(2, 5)), int'($urandom_range(2, 6)));
        end
        drain("random");
        check_eq("final_cfg", {6'd0, cfg}, {6'd0, model_cfg});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
